// File: rtl/hps_bridge_pkg.sv
// hps_bridge_pkg: shared definitions for the HPS bridge responder.
//   state_t        responder FSM states (IDLE, WR_BURST, RD_BURST)
//   ID_VALUE       contents of the read-only ID word
//   UNMAPPED_VALUE value returned for reads of unmapped words
//   WA_*           word addresses of the register map
//   is_ram()       true when a word address falls in the scratch RAM window
//   ram_index()    scratch RAM row for a word address inside that window
package hps_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR_BURST = 2'd1,
      RD_BURST = 2'd2
   } state_t;

   localparam logic [31:0] ID_VALUE       = 32'hDE10_0001;
   localparam logic [31:0] UNMAPPED_VALUE = 32'hDEAD_BEEF;

   localparam logic [31:0] WA_ID       = 32'h0000_0000;
   localparam logic [31:0] WA_LED      = 32'h0000_0001;
   localparam logic [31:0] WA_BOARD    = 32'h0000_0002;
   localparam logic [31:0] WA_STATS    = 32'h0000_0003;
   localparam logic [31:0] WA_RAM_BASE = 32'h0000_0004;
   localparam logic [31:0] WA_RAM_LAST = 32'h0000_0013;

   function automatic logic is_ram(input logic [31:0] word);
      return (word >= WA_RAM_BASE) && (word <= WA_RAM_LAST);
   endfunction

   function automatic logic [3:0] ram_index(input logic [31:0] word);
      return 4'(word - WA_RAM_BASE);
   endfunction

endpackage

// File: rtl/hps_bridge_responder_if.sv
// hps_bridge_responder_if: Avalon-MM slave bus of the HPS bridge responder.
//   avs_address/avs_burstcount  first-beat word address and beat count
//   avs_read/avs_write          command strobes
//   avs_writedata/avs_byteenable write data and per-byte enables
//   avs_debugaccess             carried for completeness, ignored by the slave
//   avs_waitrequest/avs_readdata/avs_readdatavalid  slave responses
// Modports: master (drives commands), slave (drives responses).
interface hps_bridge_responder_if #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned BURST_W = 4
);

   logic [ADDR_W-1:0]  avs_address;
   logic [BURST_W-1:0] avs_burstcount;
   logic               avs_read;
   logic               avs_write;
   logic [31:0]        avs_writedata;
   logic [3:0]         avs_byteenable;
   logic               avs_debugaccess;
   logic               avs_waitrequest;
   logic [31:0]        avs_readdata;
   logic               avs_readdatavalid;

   modport master (
      output avs_address, avs_burstcount, avs_read, avs_write,
             avs_writedata, avs_byteenable, avs_debugaccess,
      input  avs_waitrequest, avs_readdata, avs_readdatavalid
   );

   modport slave (
      input  avs_address, avs_burstcount, avs_read, avs_write,
             avs_writedata, avs_byteenable, avs_debugaccess,
      output avs_waitrequest, avs_readdata, avs_readdatavalid
   );

endinterface

// File: rtl/hps_bridge_regfile.sv
// hps_bridge_regfile: 16 x 32 scratch RAM.
//   clk    system clock
//   we     write strobe; waddr/wdata/be select row, data and enabled bytes
//   re     read strobe; rdata is loaded from row raddr on the same edge and
//          holds between reads
// Contents are deliberately not reset.
module hps_bridge_regfile (
   input  logic        clk,
   input  logic        we,
   input  logic [3:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   input  logic        re,
   input  logic [3:0]  raddr,
   output logic [31:0] rdata
);

   logic [31:0] mem [16];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/hps_bridge_responder.sv
// hps_bridge_responder: Avalon-MM burst slave exposing an ID word, an LED
// register, synchronised board inputs, an optional statistics word and a
// 16-word scratch RAM.
//   clk, reset  system clock, synchronous active-high reset
//   avs         slave side of hps_bridge_responder_if
//   led         LED register (word 0x01, bits [7:0])
//   sw, key     board inputs, double-flopped before use (word 0x02)
// Build option: define HPS_BRIDGE_RESP_STATS_EN to implement saturating
// write/read beat counters behind word 0x03; otherwise that word reads 0.
module hps_bridge_responder
   import hps_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned BURST_W = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   hps_bridge_responder_if.slave  avs,
   output logic [7:0]             led,
   input  logic [3:0]             sw,
   input  logic [1:0]             key
);

   state_t             state, state_nxt;
   logic [ADDR_W-1:0]  addr, addr_nxt;
   logic [BURST_W-1:0] rem, rem_nxt, beats;
   logic [ADDR_W-1:0]  commit_addr, fetch_addr;
   logic               commit_en, fetch_en;
   logic [31:0]        commit_word, fetch_word;
   logic               commit_is_ram, fetch_is_ram;
   logic [31:0]        fetch_csr, stats_word;
   logic               rd_valid, sel_ram;
   logic [31:0]        csr_q, ram_q;
   logic [3:0]         sw_meta, sw_sync;
   logic [1:0]         key_meta, key_sync;
   logic               unused_debugaccess;

   assign unused_debugaccess = avs.avs_debugaccess;

   // Burst length with a burstcount of 0 treated as a single beat.
   assign beats = (avs.avs_burstcount == '0) ? BURST_W'(1) : avs.avs_burstcount;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         addr     <= '0;
         rem      <= '0;
         rd_valid <= 1'b0;
         csr_q    <= '0;
         sel_ram  <= 1'b0;
         led      <= '0;
         sw_meta  <= '0;
         sw_sync  <= '0;
         key_meta <= '0;
         key_sync <= '0;
      end else begin
         state    <= state_nxt;
         addr     <= addr_nxt;
         rem      <= rem_nxt;
         rd_valid <= fetch_en;
         if (fetch_en) begin
            csr_q   <= fetch_csr;
            sel_ram <= fetch_is_ram;
         end
         if (commit_en && (commit_word == WA_LED) && avs.avs_byteenable[0]) begin
            led <= avs.avs_writedata[7:0];
         end
         sw_meta  <= sw;
         sw_sync  <= sw_meta;
         key_meta <= key;
         key_sync <= key_meta;
      end
   end

   // rem counts beats still to be transferred after the current one. In
   // RD_BURST the beat on the bus is the one fetched on the previous edge, so
   // the state is held exactly as long as readdatavalid is high.
   always_comb begin
      state_nxt   = state;
      addr_nxt    = addr;
      rem_nxt     = rem;
      commit_en   = 1'b0;
      commit_addr = addr;
      fetch_en    = 1'b0;
      fetch_addr  = addr;
      unique case (state)
         IDLE: begin
            if (avs.avs_write) begin
               commit_en   = 1'b1;
               commit_addr = avs.avs_address;
               addr_nxt    = avs.avs_address + ADDR_W'(1);
               rem_nxt     = beats - BURST_W'(1);
               if (beats != BURST_W'(1)) begin
                  state_nxt = WR_BURST;
               end
            end else if (avs.avs_read) begin
               fetch_en   = 1'b1;
               fetch_addr = avs.avs_address;
               addr_nxt   = avs.avs_address + ADDR_W'(1);
               rem_nxt    = beats - BURST_W'(1);
               state_nxt  = RD_BURST;
            end
         end
         WR_BURST: begin
            if (avs.avs_write) begin
               commit_en = 1'b1;
               addr_nxt  = addr + ADDR_W'(1);
               rem_nxt   = rem - BURST_W'(1);
               if (rem == BURST_W'(1)) begin
                  state_nxt = IDLE;
               end
            end
         end
         RD_BURST: begin
            if (rem != '0) begin
               fetch_en = 1'b1;
               addr_nxt = addr + ADDR_W'(1);
               rem_nxt  = rem - BURST_W'(1);
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign commit_word   = 32'(commit_addr);
   assign commit_is_ram = is_ram(commit_word);

   always_comb begin
      fetch_word   = 32'(fetch_addr);
      fetch_is_ram = 1'b0;
      fetch_csr    = UNMAPPED_VALUE;
      if (fetch_word == WA_ID) begin
         fetch_csr = ID_VALUE;
      end else if (fetch_word == WA_LED) begin
         fetch_csr = {24'h0, led};
      end else if (fetch_word == WA_BOARD) begin
         fetch_csr = {26'h0, key_sync, sw_sync};
      end else if (fetch_word == WA_STATS) begin
         fetch_csr = stats_word;
      end else if (is_ram(fetch_word)) begin
         fetch_is_ram = 1'b1;
         fetch_csr    = '0;
      end
   end

   hps_bridge_regfile u_regfile (
      .clk   (clk),
      .we    (commit_en && commit_is_ram && !reset),
      .waddr (ram_index(commit_word)),
      .wdata (avs.avs_writedata),
      .be    (avs.avs_byteenable),
      .re    (fetch_en && fetch_is_ram && !reset),
      .raddr (ram_index(fetch_word)),
      .rdata (ram_q)
   );

`ifdef HPS_BRIDGE_RESP_STATS_EN
   logic [15:0] wr_beats, rd_beats;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_beats <= '0;
         rd_beats <= '0;
      end else begin
         if (commit_en && (wr_beats != '1)) begin
            wr_beats <= wr_beats + 16'd1;
         end
         // A read beat counts once it is actually on the bus.
         if (rd_valid && (rd_beats != '1)) begin
            rd_beats <= rd_beats + 16'd1;
         end
      end
   end

   assign stats_word = {wr_beats, rd_beats};
`else
   assign stats_word = '0;
`endif

   // Both data sources are registers loaded only on a fetch, so readdata
   // holds its last beat while readdatavalid is low.
   assign avs.avs_readdata      = sel_ram ? ram_q : csr_q;
   assign avs.avs_readdatavalid = rd_valid;
   assign avs.avs_waitrequest   = (state == RD_BURST);

endmodule
